// File: rtl/mem_loader.sv
// mem_loader: streams 2^ADDR_W words from a valid/ready input into a memory
// write port. Optional checksum output when MEM_LOADER_CHECKSUM_EN is defined.
//
// Ports:
//   clk, rst_n       : clock, async active-low reset
//   start_load       : level request, rising edge starts a load
//   in_data/in_valid : input word stream
//   in_ready         : high while loading
//   mem_address/mem_data/mem_we : registered write port, 1-cycle latency
//   busy             : load in progress or final write still pending
//   load_done        : all words of the last load written
//   checksum         : (MEM_LOADER_CHECKSUM_EN) XOR of words accepted this load
module mem_loader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_load,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_we,
  output logic              busy,
`ifdef MEM_LOADER_CHECKSUM_EN
  output logic [DATA_W-1:0] checksum,
`endif
  output logic              load_done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [ADDR_W-1:0] LAST = '1;

  logic [1:0]        state_q, state_d;
  logic              start_q;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              we_q, we_d;
  logic              done_q, done_d;
  logic              start_pulse;
  logic              accept;
`ifdef MEM_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;
`endif

  always_comb begin
    start_pulse = start_load & ~start_q;
    accept      = in_valid & (state_q == LOAD);
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = accept;
    addr_d      = addr_q;
    data_d      = data_q;
    done_d      = done_q;
    case (state_q)
      IDLE: begin
        done_d = 1'b0;
        if (start_pulse) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        if (accept) begin
          cnt_d = cnt_q + ADDR_W'(1);
          if (cnt_q == LAST) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        // we_q in DONE is the final write; done follows it by one cycle
        if (we_q) begin
          done_d = 1'b1;
        end
        if (start_pulse) begin
          state_d = LOAD;
          cnt_d   = '0;
          done_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        done_d  = 1'b0;
      end
    endcase
    if (accept) begin
      addr_d = cnt_q;
      data_d = in_data;
    end
  end

`ifdef MEM_LOADER_CHECKSUM_EN
  always_comb begin
    sum_d = sum_q;
    if (start_pulse && (state_q != LOAD)) begin
      sum_d = '0;
    end else if (accept) begin
      sum_d = sum_q ^ in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign checksum = sum_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_load;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      done_q  <= done_d;
    end
  end

  // we_q can only be high in LOAD or right after the final accept
  assign in_ready    = (state_q == LOAD);
  assign busy        = (state_q == LOAD) | we_q;
  assign mem_we      = we_q;
  assign mem_address = addr_q;
  assign mem_data    = data_q;
  assign load_done   = done_q;

endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: randomized scoreboard bench for mem_loader.
// Build with MEM_LOADER_CHECKSUM_EN to also check the checksum output.
module tb_mem_loader;

  localparam int AW = 5;
  localparam int DW = 64;
  localparam int NW = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_load = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data;
  logic          mem_we;
  logic          busy;
  logic          load_done;
`ifdef MEM_LOADER_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  mem_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_load (start_load),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .mem_address(mem_address),
    .mem_data   (mem_data),
    .mem_we     (mem_we),
    .busy       (busy),
`ifdef MEM_LOADER_CHECKSUM_EN
    .checksum   (checksum),
`endif
    .load_done  (load_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_wr    = 0;

  // reference model: plain load bookkeeping
  logic          m_prev, m_loading, m_done, m_last, m_we;
  int            m_idx;
  logic [DW-1:0] m_sum;
  int            qa[$];
  logic [DW-1:0] qd[$];

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_prev    <= 1'b0;
      m_loading <= 1'b0;
      m_done    <= 1'b0;
      m_last    <= 1'b0;
      m_we      <= 1'b0;
      m_idx     <= 0;
      m_sum     <= '0;
      qa.delete();
      qd.delete();
    end else begin
      m_prev <= start_load;
      m_we   <= 1'b0;
      if (m_last) begin
        m_done <= 1'b1;
        m_last <= 1'b0;
      end
      if (m_loading && in_valid) begin
        qa.push_back(m_idx);
        qd.push_back(in_data);
        m_we  <= 1'b1;
        m_sum <= m_sum ^ in_data;
        m_idx <= m_idx + 1;
        if (m_idx == NW - 1) begin
          m_loading <= 1'b0;
          m_last    <= 1'b1;
        end
      end
      if (start_load && !m_prev && !m_loading) begin
        m_loading <= 1'b1;
        m_idx     <= 0;
        m_done    <= 1'b0;
        m_last    <= 1'b0;
        m_sum     <= '0;
      end
    end
  end

  // monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst in_ready", {63'd0, in_ready}, '0);
      chk("rst mem_we", {63'd0, mem_we}, '0);
      chk("rst mem_address", {59'd0, mem_address}, '0);
      chk("rst mem_data", mem_data, '0);
      chk("rst busy", {63'd0, busy}, '0);
      chk("rst load_done", {63'd0, load_done}, '0);
    end else begin
      chk("in_ready", {63'd0, in_ready}, {63'd0, m_loading});
      chk("busy", {63'd0, busy}, {63'd0, m_loading | m_we});
      chk("load_done", {63'd0, load_done}, {63'd0, m_done});
      chk("mem_we", {63'd0, mem_we}, {63'd0, m_we});
`ifdef MEM_LOADER_CHECKSUM_EN
      if (m_done) chk("checksum", checksum, m_sum);
`endif
      if (mem_we) begin
        n_wr++;
        if (qa.size() == 0) begin
          chk("unexpected write", 64'd1, 64'd0);
        end else begin
          chk("mem_address", {59'd0, mem_address}, DW'(qa.pop_front()));
          chk("mem_data", mem_data, qd.pop_front());
        end
      end
    end
  end

  // mode 0: valid always, data=index; 1: toggle; 2: random; 3: 1<<index
  task automatic feed(input int mode, input int glitch, input int budget);
    int n = 0;
    logic tg = 1'b1;
    forever begin
      @(negedge clk);
      if (m_done && qa.size() == 0) break;
      n++;
      if (n > budget) begin
        chk("load timeout", 64'd1, 64'd0);
        break;
      end
      if (m_idx == glitch) start_load = 1'b0;
      if (m_idx == glitch + 1) start_load = 1'b1;
      case (mode)
        0: begin in_valid = 1'b1; in_data = DW'(m_idx); end
        1: begin in_valid = tg; tg = ~tg; in_data = {$urandom, $urandom}; end
        2: begin in_valid = 1'($urandom); in_data = {$urandom, $urandom}; end
        default: begin in_valid = 1'b1; in_data = 64'd1 << m_idx; end
      endcase
    end
    in_valid = 1'b0;
  endtask

  task automatic new_start();
    @(negedge clk);
    start_load = 1'b0;
    @(negedge clk);
    start_load = 1'b1;
    n_wr = 0;
  endtask

  task automatic idle(input int n, input logic rnd);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = rnd ? 1'($urandom) : 1'b0;
      in_data  = {$urandom, $urandom};
    end
    in_valid = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(4, 1'b1);

    // continuous stream, data = index
    new_start();
    feed(0, -5, 200);
    chk("writes cont", DW'(n_wr), DW'(NW));
    idle(3, 1'b1);

    // toggling valid
    new_start();
    feed(1, -5, 200);
    chk("writes toggle", DW'(n_wr), DW'(NW));

    // start held high ~100 cycles: one load only
    new_start();
    feed(2, -5, 90);
    idle(100 - 32, 1'b1);
    chk("writes held", DW'(n_wr), DW'(NW));
    new_start();
    feed(2, -5, 300);
    chk("writes restart", DW'(n_wr), DW'(NW));

    // start pulse at word 10 ignored
    new_start();
    feed(0, 10, 200);
    chk("writes glitch", DW'(n_wr), DW'(NW));

    // reset after word 15 accepted, start held through release
    new_start();
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (m_idx == 16) break;
      in_data = DW'(m_idx);
    end
    #1 rst_n = 1'b0;
    #1;
    chk("abort mem_we", {63'd0, mem_we}, '0);
    chk("abort busy", {63'd0, busy}, '0);
    chk("abort addr", {59'd0, mem_address}, '0);
    idle(2, 1'b1);
    start_load = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    n_wr = 0;
    feed(0, -5, 200);
    chk("writes after rst", DW'(n_wr), DW'(NW));

    // one-hot data
    new_start();
    feed(3, -5, 200);
`ifdef MEM_LOADER_CHECKSUM_EN
    chk("checksum onehot", checksum, 64'h00000000FFFFFFFF);
`endif
    idle(3, 1'b0);
    chk("queue empty", DW'(qa.size()), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
